// File: rtl/wvb_rd_arbiter_pkg.sv
// Shared waveform-buffer definitions: read-arbiter state encoding and length helper.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package wvb_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } wvb_rd_state_t;

    // Waveform length in words for an inclusive start/stop pair on an aw-bit
    // circular buffer: stop below start wraps through address 0, equal gives 1.
    function automatic logic [32:0] wvb_len(input logic [31:0] start,
                                            input logic [31:0] stop,
                                            input int unsigned aw);
        logic [31:0] mask;
        mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
        return {1'b0, (stop - start) & mask} + 33'd1;
    endfunction

endpackage

// File: rtl/wvb_rd_arbiter_rr_prio_sel.sv
// Round-robin priority select: first requester after the last-served index wins.
// Latency: purely combinational.
// Backpressure: none; grant is only meaningful while vld is high.
module rr_prio_sel
    import wvb_rd_arbiter_pkg::*;
#(
    parameter int P_N = 4,
    localparam int CW = $clog2(P_N)
) (
    input  logic [P_N-1:0] req,
    input  logic [CW-1:0]  last,
    output logic [CW-1:0]  grant,
    output logic           vld
);

    logic [CW-1:0] cand;

    // Scan from farthest to nearest so the nearest requester after 'last' overwrites the rest.
    always_comb begin
        grant = '0;
        vld   = 1'b0;
        cand  = '0;
        for (int k = P_N; k >= 1; k--) begin
            cand = CW'((32'(last) + 32'(k)) % P_N);
            if (req[cand]) begin
                grant = cand;
                vld   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wvb_rd_arbiter.sv
// Round-robin reader of per-channel waveform buffers into one sop/eop sample stream.
// Latency: header pop 1 cycle after grant; first word 2 cycles after the pop; data 1 cycle after each read.
// Backpressure: dout_ready low stalls reads and holds the address; one in-flight word may still emerge.
module wvb_rd_arbiter
    import wvb_rd_arbiter_pkg::*;
#(
    parameter int P_N_CHAN     = 4,
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [P_N_CHAN-1:0]              hdr_empty,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic [P_N_CHAN-1:0]              hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]           wvb_rd_addr,
    input  logic [P_N_CHAN*P_DATA_WIDTH-1:0] wvb_rd_data,
    input  logic                             dout_ready,
    output logic [P_DATA_WIDTH-1:0]          dout_data,
    output logic                             dout_valid,
    output logic                             dout_sop,
    output logic                             dout_eop,
    output logic [$clog2(P_N_CHAN)-1:0]      dout_chan,
    output logic [P_N_CHAN-1:0]              rd_done,
    output logic                             busy
);

    localparam int CW    = $clog2(P_N_CHAN);
    localparam int CNT_W = P_ADR_WIDTH + 1;

    wvb_rd_state_t state, state_nxt;

    logic [CW-1:0]           grant;
    logic [CW-1:0]           last_served;
    logic [CW-1:0]           sel_grant;
    logic                    sel_vld;
    logic [CNT_W-1:0]        cnt;          // reads still to issue, including the current one
    logic                    first_word;
    logic                    issue;
    logic                    final_rd;

    logic [P_ADR_WIDTH-1:0]  start_arr [P_N_CHAN];
    logic [P_ADR_WIDTH-1:0]  stop_arr  [P_N_CHAN];
    logic [P_DATA_WIDTH-1:0] data_arr  [P_N_CHAN];

    for (genvar k = 0; k < P_N_CHAN; k++) begin : g_unpack
        assign start_arr[k] = hdr_start_addr[k*P_ADR_WIDTH +: P_ADR_WIDTH];
        assign stop_arr[k]  = hdr_stop_addr[k*P_ADR_WIDTH +: P_ADR_WIDTH];
        assign data_arr[k]  = wvb_rd_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    rr_prio_sel #(.P_N(P_N_CHAN)) u_sel (
        .req   (~hdr_empty),
        .last  (last_served),
        .grant (sel_grant),
        .vld   (sel_vld)
    );

    assign final_rd  = (cnt == CNT_W'(1));
    assign busy      = (state != S_IDLE);
    assign dout_chan = grant;
    // Buffer data arrives one cycle after its address, aligned with the registered valid.
    assign dout_data = dout_valid ? data_arr[grant] : '0;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: if (sel_vld) state_nxt = S_HDR;
            S_HDR:  state_nxt = S_DATA;
            S_DATA: begin
                if (dout_ready) begin
                    issue = 1'b1;
                    if (final_rd) state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered strobes; header fields are sampled before the pop takes effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_rdreq   <= '0;
            rd_done     <= '0;
            dout_valid  <= 1'b0;
            dout_sop    <= 1'b0;
            dout_eop    <= 1'b0;
            wvb_rd_addr <= '0;
            grant       <= '0;
            last_served <= CW'(P_N_CHAN - 1);
            cnt         <= '0;
            first_word  <= 1'b0;
        end else begin
            hdr_rdreq  <= '0;
            rd_done    <= '0;
            dout_valid <= issue;
            dout_sop   <= issue & first_word;
            dout_eop   <= issue & final_rd;
            case (state)
                S_IDLE: begin
                    if (sel_vld) begin
                        grant                <= sel_grant;
                        hdr_rdreq[sel_grant] <= 1'b1;
                    end
                end
                S_HDR: begin
                    wvb_rd_addr <= start_arr[grant];
                    cnt         <= CNT_W'(wvb_len(32'(start_arr[grant]), 32'(stop_arr[grant]),
                                                  P_ADR_WIDTH));
                    first_word  <= 1'b1;
                end
                S_DATA: begin
                    if (issue) begin
                        wvb_rd_addr <= wvb_rd_addr + P_ADR_WIDTH'(1);
                        cnt         <= cnt - CNT_W'(1);
                        first_word  <= 1'b0;
                        if (final_rd) rd_done[grant] <= 1'b1;
                    end
                end
                S_DONE: last_served <= grant;
                default: ;
            endcase
        end
    end

endmodule
